// File: rtl/exc_stage.sv
// Exception stage: registers the MEM-stage instruction, resolves a single exception cause
// for CP0, and flushes/redirects the pipeline once CP0 reports an exception taken.
//   state    | meaning
//   IDLE     | normal flow; stage register follows MEM unless stalled
//   REDIRECT | presenting redirect_pc to fetch until redirect_ready; stage squashed
module exc_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_stall,
    input  logic [31:0] in_pc,
    input  logic        in_is_in_ds,
    input  logic        in_if_adel,
    input  logic        in_ri,
    input  logic        in_sys,
    input  logic        in_bp,
    input  logic        in_ov,
    input  logic        in_eret,
    input  logic        in_mem_adel,
    input  logic        in_mem_ades,
    input  logic [31:0] in_mem_addr,
    output logic        reg_valid,
    output logic [31:0] pre_pc,
    output logic [31:0] pre_badvaddr,
    output logic [4:0]  pre_excCode,
    output logic        pre_is_exc,
    output logic        pre_is_in_ds,
    output logic        pre_is_eret,
    input  logic        exc_occur,
    input  logic [31:0] exc_pc,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t      state_q, state_d;
    logic        squash;

    logic        valid_q;
    logic [31:0] pc_q;
    logic        ds_q;
    logic        exc_q;
    logic        eret_q;
    logic [4:0]  code_q;
    logic [31:0] badv_q;
    logic [31:0] redirect_pc_q;

    logic        cause_exc;
    logic        cause_eret;
    logic [4:0]  cause_code;
    logic [31:0] cause_badv;

    // Fixed-priority cause selection; eret only wins when nothing else is pending.
    always_comb begin
        cause_exc  = 1'b1;
        cause_eret = 1'b0;
        cause_code = EXC_INT;
        cause_badv = 32'd0;
        if (in_if_adel) begin
            cause_code = EXC_ADEL;
            cause_badv = in_pc;
        end else if (in_ri) begin
            cause_code = EXC_RI;
        end else if (in_sys) begin
            cause_code = EXC_SYS;
        end else if (in_bp) begin
            cause_code = EXC_BP;
        end else if (in_ov) begin
            cause_code = EXC_OV;
        end else if (in_mem_adel) begin
            cause_code = EXC_ADEL;
            cause_badv = in_mem_addr;
        end else if (in_mem_ades) begin
            cause_code = EXC_ADES;
            cause_badv = in_mem_addr;
        end else if (in_eret) begin
            cause_eret = 1'b1;
        end else begin
            cause_exc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || squash) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            ds_q    <= 1'b0;
            exc_q   <= 1'b0;
            eret_q  <= 1'b0;
            code_q  <= 5'd0;
            badv_q  <= 32'd0;
        end else if (!in_stall) begin
            valid_q <= in_valid;
            pc_q    <= in_pc;
            ds_q    <= in_is_in_ds;
            exc_q   <= in_valid && cause_exc;
            eret_q  <= in_valid && cause_eret;
            code_q  <= in_valid ? cause_code : 5'd0;
            badv_q  <= in_valid ? cause_badv : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_pc_q <= 32'd0;
        end else if (state_q == IDLE && exc_occur) begin
            redirect_pc_q <= exc_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (exc_occur)      state_d = REDIRECT;
            REDIRECT: if (redirect_ready) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        flush          = 1'b0;
        redirect_valid = 1'b0;
        reg_valid      = 1'b0;
        squash         = 1'b0;
        case (state_q)
            IDLE: begin
                reg_valid = valid_q && !in_stall;
                flush     = exc_occur;
                squash    = exc_occur;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                squash         = 1'b1;
            end
            default: ;
        endcase
    end

    assign pre_pc       = pc_q;
    assign pre_is_in_ds = ds_q;
    assign pre_is_exc   = exc_q;
    assign pre_is_eret  = eret_q;
    assign pre_excCode  = code_q;
    assign pre_badvaddr = badv_q;
    assign redirect_pc  = redirect_pc_q;

endmodule
